// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-cache request/response bus between fetch and I-cache
interface fetch_stage_if;
   logic        icache_req_valid;
   logic [31:0] icache_req_addr;
   logic        icache_resp_valid;
   logic [31:0] icache_resp_data;
   modport master (output icache_req_valid, icache_req_addr, input icache_resp_valid, icache_resp_data);
   modport slave  (input icache_req_valid, icache_req_addr, output icache_resp_valid, icache_resp_data);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, I-cache requests, IF/ID register with one-entry stall buffer and redirects (optional counters: FETCH_PERF_CNT_EN)
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_1000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          PC_STEP   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   fetch_stage_if.master        ic,
   input  logic                 en_reg_decode,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   output logic [31:0]          instr_out,
   output logic [31:0]          pc_out,
   output logic                 instr_valid,
   output logic                 block_pipe_instr_cache
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          perf_fetch_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);
   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_HOLD  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d, hold_q, hold_d, rpc_q, rpc_d;
   logic [31:0] instr_q, instr_d, pco_q, pco_d;
   logic        pend_q, pend_d, valid_q, valid_d;
   logic        fetching, resp, deliver;
   logic [31:0] pc_inc;

   assign fetching = state_q == S_FETCH;
   assign resp     = fetching & ic.icache_resp_valid;
   assign pc_inc   = pc_q + 32'(PC_STEP);

   assign ic.icache_req_valid   = reset & fetching;
   assign ic.icache_req_addr    = pc_q;
   assign block_pipe_instr_cache = reset & fetching & ~ic.icache_resp_valid;
   assign instr_out   = instr_q;
   assign pc_out      = pco_q;
   assign instr_valid = valid_q;

   // Next-state: a redirect always flushes IF/ID; a redirect during an in-flight request is deferred until the response retires it
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      pend_d  = pend_q;
      rpc_d   = rpc_q;
      instr_d = instr_q;
      pco_d   = pco_q;
      valid_d = valid_q;
      deliver = 1'b0;
      if (branch_taken) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         if (!fetching || resp) begin
            pc_d    = branch_target;
            state_d = S_FETCH;
            pend_d  = 1'b0;
         end else begin
            pend_d = 1'b1;
            rpc_d  = branch_target;
         end
      end else if (!fetching) begin
         if (en_reg_decode) begin
            instr_d = hold_q;
            pco_d   = pc_q;
            valid_d = 1'b1;
            deliver = 1'b1;
            pc_d    = pc_inc;
            state_d = S_FETCH;
         end
      end else if (resp && pend_q) begin
         pc_d   = rpc_q;
         pend_d = 1'b0;
         if (en_reg_decode) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end else if (resp && en_reg_decode) begin
         instr_d = ic.icache_resp_data;
         pco_d   = pc_q;
         valid_d = 1'b1;
         deliver = 1'b1;
         pc_d    = pc_inc;
      end else if (resp) begin
         hold_d  = ic.icache_resp_data;
         state_d = S_HOLD;
      end else if (en_reg_decode) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         hold_q  <= '0;
         pend_q  <= 1'b0;
         rpc_q   <= '0;
         instr_q <= NOP_INSTR;
         pco_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         rpc_q   <= rpc_d;
         instr_q <= instr_d;
         pco_q   <= pco_d;
         valid_q <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fcnt_q, scnt_q;
   assign perf_fetch_cnt = fcnt_q;
   assign perf_stall_cnt = scnt_q;

   // Saturating counters of delivered instructions and I-cache stall cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         fcnt_q <= '0;
         scnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 32'(deliver && fcnt_q != '1);
         scnt_q <= scnt_q + 32'(block_pipe_instr_cache && scnt_q != '1);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random checks of fetch_stage against a cycle-level reference model
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en_reg_decode = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] instr_out, pc_out;
   logic        instr_valid, block_pipe_instr_cache;
   int          checks = 0;
   int          errors = 0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
   logic [31:0] m_fc = '0, m_sc = '0;
`endif

   logic [31:0] m_pc = 32'h1000, m_buf = '0, m_rpc = '0, m_instr = '0, m_pco = '0;
   logic        m_hold = 1'b0, m_pend = 1'b0, m_valid = 1'b0;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk                    (clk),
      .reset                  (reset),
      .ic                     (bus),
      .en_reg_decode          (en_reg_decode),
      .branch_taken           (branch_taken),
      .branch_target          (branch_target),
      .instr_out              (instr_out),
      .pc_out                 (pc_out),
      .instr_valid            (instr_valid),
      .block_pipe_instr_cache (block_pipe_instr_cache)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt         (perf_fetch_cnt),
      .perf_stall_cnt         (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic give(input logic [31:0] d);
      m_instr = d;
      m_pco   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
      if (m_fc != '1) m_fc++;
`endif
   endtask

   task automatic bubble();
      m_instr = 32'h0;
      m_valid = 1'b0;
   endtask

   // One clock: drive inputs, check the combinational request side, advance the model, check IF/ID after the edge
   task automatic cyc(input logic r, input logic en, input logic br, input logic [31:0] tgt,
                      input logic rv, input logic [31:0] rd);
      logic exp_req, exp_blk, got_resp;
      reset = r; en_reg_decode = en; branch_taken = br; branch_target = tgt;
      bus.icache_resp_valid = rv; bus.icache_resp_data = rd;
      #1;
      exp_req = r && !m_hold;
      exp_blk = exp_req && !rv;
      chk("req_valid", {31'b0, bus.icache_req_valid}, {31'b0, exp_req});
      chk("block", {31'b0, block_pipe_instr_cache}, {31'b0, exp_blk});
      if (exp_req) chk("req_addr", bus.icache_req_addr, m_pc);
      got_resp = !m_hold && rv;
      if (!r) begin
         m_pc = 32'h1000; m_hold = 0; m_buf = 0; m_pend = 0; m_rpc = 0;
         m_instr = 0; m_pco = 0; m_valid = 0;
`ifdef FETCH_PERF_CNT_EN
         m_fc = 0; m_sc = 0;
`endif
      end else begin
`ifdef FETCH_PERF_CNT_EN
         if (exp_blk && m_sc != '1) m_sc++;
`endif
         if (br) begin
            bubble();
            if (m_hold || got_resp) begin m_pc = tgt; m_hold = 0; m_pend = 0; end
            else begin m_pend = 1; m_rpc = tgt; end
         end else if (m_hold) begin
            if (en) begin give(m_buf); m_hold = 0; end
         end else if (got_resp && m_pend) begin
            m_pc = m_rpc; m_pend = 0;
            if (en) bubble();
         end else if (got_resp) begin
            if (en) give(rd);
            else begin m_buf = rd; m_hold = 1; end
         end else if (en) bubble();
      end
      @(posedge clk);
      #1;
      chk("instr_out", instr_out, m_instr);
      chk("pc_out", pc_out, m_pco);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fc);
      chk("perf_stall", perf_stall_cnt, m_sc);
`endif
   endtask

   initial begin
      bus.icache_resp_valid = 1'b0;
      bus.icache_resp_data  = '0;
      // reset, then three same-cycle hits
      cyc(0, 1, 0, 0, 1, 32'hDEAD);
      cyc(0, 1, 0, 0, 0, 0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_addr", bus.icache_req_addr, 32'h1000);
      cyc(1, 1, 0, 0, 1, 32'hA);
      chk("hitA", instr_out, 32'hA);
      chk("hitA_pc", pc_out, 32'h1000);
      cyc(1, 1, 0, 0, 1, 32'hB);
      chk("hitB_pc", pc_out, 32'h1004);
      cyc(1, 1, 0, 0, 1, 32'hC);
      chk("hitC_pc", pc_out, 32'h1008);
      // three-cycle miss at 0x1000
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, 0, 0);
         chk("miss_bubble", instr_out, 32'h0);
         chk("miss_addr", bus.icache_req_addr, 32'h1000);
      end
      cyc(1, 1, 0, 0, 1, 32'h1111);
      chk("miss_pc", pc_out, 32'h1000);
      // decode stall: capture into hold buffer, release two cycles later
      cyc(1, 0, 0, 0, 1, 32'h2222);
      chk("hold_reqv", {31'b0, bus.icache_req_valid}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("held_instr", instr_out, 32'h2222);
      chk("held_pc", pc_out, 32'h1004);
      chk("after_hold_addr", bus.icache_req_addr, 32'h1008);
      // redirect during a miss at 0x1008
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 1, 32'h2000, 0, 0);
      cyc(1, 1, 0, 0, 1, 32'hBAD0);
      chk("redir_addr", bus.icache_req_addr, 32'h2000);
      // pending 0x2000 overridden by a same-cycle branch to 0x3000
      cyc(1, 1, 1, 32'h2000, 0, 0);
      cyc(1, 1, 1, 32'h3000, 1, 32'hBAD1);
      chk("newest_target", bus.icache_req_addr, 32'h3000);
      // PC wrap
      cyc(1, 1, 1, 32'hFFFF_FFFC, 1, 0);
      cyc(1, 1, 0, 0, 1, 32'h5555);
      chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
      chk("wrap_addr", bus.icache_req_addr, 32'h0);
      // five hits plus a four-cycle miss
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 1, $urandom);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, $urandom);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch6", perf_fetch_cnt, 32'd6);
      chk("perf_stall4", perf_stall_cnt, 32'd4);
      cyc(0, 1, 0, 0, 0, 0);
      chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
      chk("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
      // random traffic
      for (int i = 0; i < 600; i++)
         cyc(($urandom % 50) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
             $urandom & 32'hFFFF_FFFC, ($urandom % 3) == 0, $urandom);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
